norm_share_arbiter: RTL and testbench

- Shares one downstream normalizer stage among NUM_CH independent valid/ready pixel streams.
- Grants are round-robin and packet-granular. A grant is held until the packet's last beat or until the MAX_BEATS starvation guard fires.
- Holds a per-channel normalization factor register, written by the configuration port. The factor is snapshotted at grant time and presented with the granted channel's data.
- Sits between the per-channel sources and the normalizer; the channel tag travels downstream as a sideband.

---
 rtl/norm_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 26 ++
 rtl/norm_share_arbiter.sv | 170 +++++++++++++++++
 tb/tb_norm_share_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and the round-robin pick helper used by the norm-path arbiters.
package norm_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int FACTOR_WIDTH_DEF = 11;
    localparam int DIN_WIDTH_DEF    = 11;

    // Returns {found, index}: first set req bit scanning from last+1, wrapping at num (num <= 8).
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] last, input int num);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = 8; k >= 1; k--) begin
            if (k <= num) begin
                idx = int'(last) + k;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (req[idx[2:0]]) begin
                    res = {1'b1, idx[2:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority encoder: lowest-distance requester after last_gnt wins.
module rr_arbiter
    import norm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_gnt,
    output logic [CH_W-1:0]   gnt,
    output logic              gnt_valid
);

    logic [7:0] req_ext;
    logic [2:0] last_ext;
    logic [3:0] pick;

    always_comb begin
        req_ext   = 8'(req);
        last_ext  = 3'(last_gnt);
        pick      = rr_pick(req_ext, last_ext, NUM_CH);
        gnt       = CH_W'(pick[2:0]);
        gnt_valid = pick[3];
    end

endmodule

// File: rtl/norm_share_arbiter.sv
// Packet-granular round-robin share of one normalizer among NUM_CH streams, with per-channel factor snapshot.
// Latency: one arbitration bubble per grant, then 1 beat/cycle combinational passthrough; m_ready stalls only the granted channel.
// Optional NORM_SHARE_ARBITER_STATS_EN adds saturating per-channel beat and forced-release counters.
module norm_share_arbiter
    import norm_pkg::*;
#(
    parameter int  NUM_CH       = 4,
    parameter int  DIN_WIDTH    = DIN_WIDTH_DEF,
    parameter int  FACTOR_WIDTH = FACTOR_WIDTH_DEF,
    parameter int  MAX_BEATS    = 256,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           s_valid,
    output logic [NUM_CH-1:0]           s_ready,
    input  logic [NUM_CH-1:0]           s_last,
    input  logic [NUM_CH*DIN_WIDTH-1:0] s_data,
    input  logic                        cfg_we,
    input  logic [CH_W-1:0]             cfg_ch,
    input  logic [FACTOR_WIDTH-1:0]     cfg_factor,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DIN_WIDTH-1:0]        m_data,
    output logic [FACTOR_WIDTH-1:0]     m_factor,
    output logic [CH_W-1:0]             m_ch,
    output logic                        m_last,
`ifdef NORM_SHARE_ARBITER_STATS_EN
    input  logic [CH_W-1:0]             stat_sel,
    output logic [31:0]                 stat_beats,
    output logic [31:0]                 stat_forced,
`endif
    output logic                        busy
);

    localparam int              BC_W       = $clog2(MAX_BEATS + 1);
    localparam logic [BC_W-1:0] BEAT_LIMIT = BC_W'(MAX_BEATS - 1);

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         gnt_q, gnt_d;
    logic [CH_W-1:0]         last_gnt_q, last_gnt_d;
    logic [FACTOR_WIDTH-1:0] fac_snap_q, fac_snap_d;
    logic [BC_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic [FACTOR_WIDTH-1:0] factor_q [NUM_CH];
    logic [FACTOR_WIDTH-1:0] factor_d [NUM_CH];
    logic [CH_W-1:0]         pick_gnt;
    logic                    pick_vld;
    logic                    accept;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr (
        .req       (s_valid),
        .last_gnt  (last_gnt_q),
        .gnt       (pick_gnt),
        .gnt_valid (pick_vld)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        fac_snap_d = fac_snap_q;
        beat_cnt_d = beat_cnt_q;
        factor_d   = factor_q;
        s_ready    = '0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_factor   = '0;
        m_ch       = '0;
        m_last     = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d      = pick_gnt;
                    last_gnt_d = pick_gnt;
                    // Reads the pre-write bank, so a same-cycle cfg write lands on the next grant.
                    fac_snap_d = factor_q[pick_gnt];
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                busy             = 1'b1;
                m_valid          = s_valid[gnt_q];
                m_data           = s_data[int'(gnt_q)*DIN_WIDTH +: DIN_WIDTH];
                m_last           = s_last[gnt_q];
                m_ch             = gnt_q;
                m_factor         = fac_snap_q;
                s_ready[gnt_q]   = m_ready;
                accept           = s_valid[gnt_q] && m_ready;
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (s_last[gnt_q] || (beat_cnt_q == BEAT_LIMIT)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
            factor_d[cfg_ch] = cfg_factor;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= CH_W'(NUM_CH - 1);
            fac_snap_q <= '0;
            beat_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                factor_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            fac_snap_q <= fac_snap_d;
            beat_cnt_q <= beat_cnt_d;
            factor_q   <= factor_d;
        end
    end

`ifdef NORM_SHARE_ARBITER_STATS_EN
    logic [31:0] stat_beats_q  [NUM_CH];
    logic [31:0] stat_beats_d  [NUM_CH];
    logic [31:0] stat_forced_q [NUM_CH];
    logic [31:0] stat_forced_d [NUM_CH];
    logic        forced;

    always_comb begin
        stat_beats_d  = stat_beats_q;
        stat_forced_d = stat_forced_q;
        // A last beat landing exactly on the limit is a normal release, not a forced one.
        forced        = accept && !s_last[gnt_q] && (beat_cnt_q == BEAT_LIMIT);
        if (accept && (stat_beats_q[gnt_q] != '1)) begin
            stat_beats_d[gnt_q] = stat_beats_q[gnt_q] + 32'd1;
        end
        if (forced && (stat_forced_q[gnt_q] != '1)) begin
            stat_forced_d[gnt_q] = stat_forced_q[gnt_q] + 32'd1;
        end
        stat_beats  = '0;
        stat_forced = '0;
        if (int'(stat_sel) < NUM_CH) begin
            stat_beats  = stat_beats_q[stat_sel];
            stat_forced = stat_forced_q[stat_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stat_beats_q[i]  <= '0;
                stat_forced_q[i] <= '0;
            end
        end else begin
            stat_beats_q  <= stat_beats_d;
            stat_forced_q <= stat_forced_d;
        end
    end
`endif

endmodule

// File: tb/tb_norm_share_arbiter.sv
// Directed bench for norm_share_arbiter: per-channel source queues, expected-beat scoreboard, negedge monitor.
module tb_norm_share_arbiter;

    localparam int NUM_CH = 4;
    localparam int DW     = 11;
    localparam int FW     = 11;
    localparam int CH_W   = 2;
    localparam int MAXB   = 4;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            last;
        logic [FW-1:0]   factor;
        logic [DW-1:0]   data;
    } beat_t;

    logic                 clk;
    logic                 rst;
    logic [NUM_CH-1:0]    s_valid;
    logic [NUM_CH-1:0]    s_ready;
    logic [NUM_CH-1:0]    s_last;
    logic [NUM_CH*DW-1:0] s_data;
    logic                 cfg_we;
    logic [CH_W-1:0]      cfg_ch;
    logic [FW-1:0]        cfg_factor;
    logic                 m_valid;
    logic                 m_ready;
    logic [DW-1:0]        m_data;
    logic [FW-1:0]        m_factor;
    logic [CH_W-1:0]      m_ch;
    logic                 m_last;
    logic                 busy;
`ifdef NORM_SHARE_ARBITER_STATS_EN
    logic [CH_W-1:0]      stat_sel;
    logic [31:0]          stat_beats;
    logic [31:0]          stat_forced;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    beat_t         exp_q[$];
    logic [DW-1:0] src_dat [NUM_CH][16];
    logic          src_lst [NUM_CH][16];
    int            rd_p    [NUM_CH];
    int            wr_p    [NUM_CH];
    logic [NUM_CH-1:0] hold;

    norm_share_arbiter #(
        .NUM_CH       (NUM_CH),
        .DIN_WIDTH    (DW),
        .FACTOR_WIDTH (FW),
        .MAX_BEATS    (MAXB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_last     (s_last),
        .s_data     (s_data),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_factor (cfg_factor),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_factor   (m_factor),
        .m_ch       (m_ch),
        .m_last     (m_last),
`ifdef NORM_SHARE_ARBITER_STATS_EN
        .stat_sel    (stat_sel),
        .stat_beats  (stat_beats),
        .stat_forced (stat_forced),
`endif
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic present();
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_p[c] < wr_p[c]) begin
                s_valid[c]         = !hold[c];
                s_last[c]          = src_lst[c][rd_p[c] % 16];
                s_data[c*DW +: DW] = src_dat[c][rd_p[c] % 16];
            end else begin
                s_valid[c]         = 1'b0;
                s_last[c]          = 1'b0;
                s_data[c*DW +: DW] = '0;
            end
        end
    endtask

    task automatic src_pkt(input int c, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            src_dat[c][wr_p[c] % 16] = DW'(base + i);
            src_lst[c][wr_p[c] % 16] = (i == n - 1);
            wr_p[c]++;
        end
        present();
    endtask

    task automatic exp_beat(input int c, input int d, input int f, input logic l);
        beat_t b;
        b.ch     = CH_W'(c);
        b.last   = l;
        b.factor = FW'(f);
        b.data   = DW'(d);
        exp_q.push_back(b);
    endtask

    task automatic cfg_write(input int c, input int f);
        cfg_we     = 1'b1;
        cfg_ch     = CH_W'(c);
        cfg_factor = FW'(f);
        @(posedge clk);
        #1;
        cfg_we     = 1'b0;
    endtask

    function automatic logic srcs_empty();
        logic e;
        e = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_p[c] != wr_p[c]) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy && srcs_empty();
        end
        check(name, done, 1);
        @(posedge clk);
        #1;
    endtask

    // Source driver: handshakes are judged mid-cycle, queues advance just after the edge.
    initial begin : driver
        logic [NUM_CH-1:0] hs;
        forever begin
            @(negedge clk);
            hs = s_valid & s_ready & {NUM_CH{!rst}};
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (hs[c]) rd_p[c]++;
            end
            present();
        end
    end

    initial begin : monitor
        beat_t got;
        beat_t req;
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
                got.ch     = m_ch;
                got.last   = m_last;
                got.factor = m_factor;
                got.data   = m_data;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: got ch=%0d data=%0d factor=%0d last=%0b, required no beat",
                             got.ch, got.data, got.factor, got.last);
                end else begin
                    req = exp_q.pop_front();
                    if (got !== req) begin
                        n_fail++;
                        $display("FAIL beat: got ch=%0d data=%0d factor=%0d last=%0b, required ch=%0d data=%0d factor=%0d last=%0b",
                                 got.ch, got.data, got.factor, got.last, req.ch, req.data, req.factor, req.last);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic found;
        rst        = 1'b1;
        m_ready    = 1'b1;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_factor = '0;
        hold       = '0;
        s_valid    = '0;
        s_last     = '0;
        s_data     = '0;
`ifdef NORM_SHARE_ARBITER_STATS_EN
        stat_sel   = '0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            rd_p[c] = 0;
            wr_p[c] = 0;
        end
        present();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_m_valid", m_valid, 0);
        check("reset_s_ready", s_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_m_data", m_data, 0);
        check("reset_m_factor", m_factor, 0);
        check("reset_m_ch", m_ch, 0);
        check("reset_m_last", m_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin: two single-beat packets per channel, order 0,1,2,3,0,1,2,3.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                exp_beat(c, 100 + 10*r + c, 0, 1'b1);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            src_pkt(c, 100 + c, 1);
            src_pkt(c, 110 + c, 1);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("rr_busy_alternates", busy, 32'(k % 2));
        end
        wait_idle("rr_drain", 20);

        // Single channel with factor 5: bubble then three busy cycles.
        cfg_write(2, 5);
        exp_beat(2, 10, 5, 1'b0);
        exp_beat(2, 20, 5, 1'b0);
        exp_beat(2, 30, 5, 1'b1);
        src_dat[2][wr_p[2] % 16] = 11'd10; src_lst[2][wr_p[2] % 16] = 1'b0; wr_p[2]++;
        src_dat[2][wr_p[2] % 16] = 11'd20; src_lst[2][wr_p[2] % 16] = 1'b0; wr_p[2]++;
        src_dat[2][wr_p[2] % 16] = 11'd30; src_lst[2][wr_p[2] % 16] = 1'b1; wr_p[2]++;
        present();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("single_busy", busy, (k >= 1 && k <= 3) ? 1 : 0);
        end
        wait_idle("single_drain", 20);

        // Backpressure: m_ready low for four cycles on beat 2.
        exp_beat(1, 40, 0, 1'b0);
        exp_beat(1, 41, 0, 1'b0);
        exp_beat(1, 42, 0, 1'b1);
        src_pkt(1, 40, 3);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_m_valid_held", m_valid, 1);
            check("bp_m_data_held", m_data, 41);
            check("bp_s_ready_low", s_ready, 0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_idle("bp_drain", 20);

        // Starvation guard: ch0 10 beats, ch1 2 beats, MAX_BEATS=4.
        for (int i = 0; i < 4; i++) exp_beat(0, 200 + i, 0, 1'b0);
        exp_beat(1, 300, 0, 1'b0);
        exp_beat(1, 301, 0, 1'b1);
        for (int i = 4; i < 8; i++) exp_beat(0, 200 + i, 0, 1'b0);
        exp_beat(0, 208, 0, 1'b0);
        exp_beat(0, 209, 0, 1'b1);
        src_pkt(0, 200, 10);
        src_pkt(1, 300, 2);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (busy && m_ch == 2'd1) found = 1'b1;
        end
        check("starve_ch1_granted", found, 1);
`ifdef NORM_SHARE_ARBITER_STATS_EN
        stat_sel = 2'd0;
        #1;
        check("stat_forced0_first", stat_forced, 1);
`endif
        wait_idle("starve_drain", 60);
`ifdef NORM_SHARE_ARBITER_STATS_EN
        stat_sel = 2'd0;
        #1;
        check("stat_forced0_total", stat_forced, 2);
        check("stat_beats0", stat_beats, 12);
        stat_sel = 2'd1;
        #1;
        check("stat_beats1", stat_beats, 7);
        check("stat_forced1", stat_forced, 0);
`endif

        // Factor shadowing: mid-packet write to the granted channel shows on its next grant.
        cfg_write(1, 7);
        exp_beat(1, 50, 7, 1'b0);
        exp_beat(1, 51, 7, 1'b0);
        exp_beat(1, 52, 7, 1'b1);
        exp_beat(1, 60, 9, 1'b1);
        src_pkt(1, 50, 3);
        src_pkt(1, 60, 1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        cfg_write(1, 9);
        wait_idle("shadow_drain", 20);

        // Write coinciding with the grant: snapshot keeps the old value.
        exp_beat(3, 70, 0, 1'b1);
        exp_beat(3, 71, 11, 1'b1);
        src_pkt(3, 70, 1);
        src_pkt(3, 71, 1);
        cfg_write(3, 11);
        wait_idle("samecycle_drain", 20);

        // Grant hold: ch0 valid drops mid-packet, ch1 must not be granted meanwhile.
        exp_beat(0, 80, 0, 1'b0);
        exp_beat(0, 81, 0, 1'b0);
        exp_beat(0, 82, 0, 1'b1);
        exp_beat(1, 90, 9, 1'b1);
        src_pkt(0, 80, 3);
        src_pkt(1, 90, 1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        hold[0] = 1'b1;
        present();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_busy", busy, 1);
            check("hold_m_valid", m_valid, 0);
            check("hold_m_ch", m_ch, 0);
        end
        @(posedge clk);
        #1;
        hold[0] = 1'b0;
        present();
        wait_idle("hold_drain", 20);

        // Reset on beat 2 of a 5-beat ch2 packet.
        exp_beat(2, 120, 5, 1'b0);
        src_pkt(2, 120, 5);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_p[2] = wr_p[2];
        present();
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_m_valid", m_valid, 0);
        check("rstmid_s_ready", s_ready, 0);
`ifdef NORM_SHARE_ARBITER_STATS_EN
        stat_sel = 2'd0;
        #1;
        check("rstmid_stat_beats0", stat_beats, 0);
        check("rstmid_stat_forced0", stat_forced, 0);
`endif
        @(posedge clk);
        #1;
        exp_beat(0, 131, 0, 1'b1);
        exp_beat(3, 130, 0, 1'b1);
        src_pkt(3, 130, 1);
        src_pkt(0, 131, 1);
        wait_idle("rstmid_drain", 20);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
